// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit BHT counters: combinational next-PC lookup for IF,
// synchronous single-port training from EX, plus saturating branch/mispredict stats.
module branch_predictor #(
  parameter int ENTRY_BITS = 6,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [ADDR_WIDTH-1:0] query_pc,
  output logic                  predict_result,
  output logic [ADDR_WIDTH-1:0] predict_npc,
  input  logic                  update_valid,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic                  update_taken,
  input  logic [ADDR_WIDTH-1:0] update_target,
  input  logic                  update_mispredict,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
);

  localparam int ENTRIES = 1 << ENTRY_BITS;
  localparam int TAG_W   = ADDR_WIDTH - ENTRY_BITS - 2;

  typedef enum logic [1:0] {
    CNT_STRONG_NT = 2'b00,
    CNT_WEAK_NT   = 2'b01,
    CNT_WEAK_T    = 2'b10,
    CNT_STRONG_T  = 2'b11
  } cnt_e;

  logic [ENTRIES-1:0]    valid_q;
  cnt_e                  cnt_q    [ENTRIES];
  logic [TAG_W-1:0]      tag_mem  [ENTRIES];
  logic [ADDR_WIDTH-1:0] tgt_mem  [ENTRIES];
  logic [31:0]           stat_branches_q;
  logic [31:0]           stat_mispredicts_q;

  logic [ENTRY_BITS-1:0] q_idx, u_idx;
  logic [TAG_W-1:0]      q_tag, u_tag;
  logic                  q_hit, u_hit, upd_en;
  cnt_e                  cnt_d;
  logic [ADDR_WIDTH-1:0] tgt_d;
  logic                  unused_pc_bits;

  assign q_idx = query_pc[ENTRY_BITS+1:2];
  assign q_tag = query_pc[ADDR_WIDTH-1:ENTRY_BITS+2];
  assign u_idx = update_pc[ENTRY_BITS+1:2];
  assign u_tag = update_pc[ADDR_WIDTH-1:ENTRY_BITS+2];
  assign unused_pc_bits = ^{query_pc[1:0], update_pc[1:0]};

  // Lookup reads pre-update contents; a same-cycle write to the same index is not bypassed.
  assign q_hit          = valid_q[q_idx] && (tag_mem[q_idx] == q_tag);
  assign predict_result = q_hit && cnt_q[q_idx][1];
  assign predict_npc    = predict_result ? tgt_mem[q_idx] : query_pc + ADDR_WIDTH'(4);

  assign upd_en = rdy_in && update_valid;
  assign u_hit  = valid_q[u_idx] && (tag_mem[u_idx] == u_tag);

  always_comb begin
    cnt_d = cnt_q[u_idx];
    tgt_d = tgt_mem[u_idx];
    if (u_hit) begin
      if (update_taken) begin
        cnt_d = (cnt_q[u_idx] == CNT_STRONG_T) ? CNT_STRONG_T : cnt_e'(cnt_q[u_idx] + 2'd1);
        tgt_d = update_target;
      end else begin
        cnt_d = (cnt_q[u_idx] == CNT_STRONG_NT) ? CNT_STRONG_NT : cnt_e'(cnt_q[u_idx] - 2'd1);
      end
    end else begin
      cnt_d = update_taken ? CNT_WEAK_T : CNT_WEAK_NT;
      tgt_d = update_taken ? update_target : '0;
    end
  end

  // NOTE: only valid/cnt/stats take the async reset; tag and target arrays stay reset-free
  // so they map onto RAM. Writes landing during reset are harmless because valid is cleared.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q            <= '0;
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_WEAK_NT;
    end else if (upd_en) begin
      // NOTE: sequential state uses non-blocking assignment so every read sees pre-edge values.
      valid_q[u_idx] <= 1'b1;
      cnt_q[u_idx]   <= cnt_d;
      if (stat_branches_q != '1) stat_branches_q <= stat_branches_q + 32'd1;
      if (update_mispredict && (stat_mispredicts_q != '1))
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (upd_en) begin
      tag_mem[u_idx] <= u_tag;
      tgt_mem[u_idx] <= tgt_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed steps push expectations, a negedge
// monitor pops and compares prediction and statistics outputs.
module tb_branch_predictor;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic [31:0] query_pc = '0;
  logic        predict_result;
  logic [31:0] predict_npc;
  logic        update_valid = 1'b0;
  logic [31:0] update_pc = '0;
  logic        update_taken = 1'b0;
  logic [31:0] update_target = '0;
  logic        update_mispredict = 1'b0;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  typedef struct {
    string       name;
    logic        res;
    logic [31:0] npc;
    logic [31:0] br;
    logic [31:0] mp;
  } exp_t;

  exp_t exp_q[$];
  logic chk_en = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  branch_predictor dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .query_pc         (query_pc),
    .predict_result   (predict_result),
    .predict_npc      (predict_npc),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_taken     (update_taken),
    .update_target    (update_target),
    .update_mispredict(update_mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk_in = ~clk_in;

  task automatic cmp(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", name, field, act, req);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the update edge.
  always @(negedge clk_in) begin
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL scoreboard: got output with no expectation queued, expected an entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp(e.name, "result", {31'd0, predict_result}, {31'd0, e.res});
        cmp(e.name, "npc", predict_npc, e.npc);
        cmp(e.name, "branches", stat_branches, e.br);
        cmp(e.name, "mispredicts", stat_mispredicts, e.mp);
      end
    end
  end

  // One cycle: drive query and optional update, queue what the lookup must show this cycle.
  task automatic step(input string name, input logic [31:0] qpc, input logic uv,
                      input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                      input logic um, input logic er, input logic [31:0] enpc,
                      input logic [31:0] ebr, input logic [31:0] emp);
    exp_t e;
    query_pc          = qpc;
    update_valid      = uv;
    update_pc         = upc;
    update_taken      = ut;
    update_target     = utgt;
    update_mispredict = um;
    e.name = name; e.res = er; e.npc = enpc; e.br = ebr; e.mp = emp;
    exp_q.push_back(e);
    chk_en = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk_in);
    #1;
    // Query while held in reset, then release.
    step("in_reset", 32'h1000, 0, 0, 0, 0, 0, 0, 32'h1004, 0, 0);
    rst_in = 1'b1;
    step("post_reset", 32'h1000, 0, 0, 0, 0, 0, 0, 32'h1004, 0, 0);

    // Train taken, then two not-taken down to strong-NT.
    step("train_t",    32'h1000, 1, 32'h1000, 1, 32'h2000, 1, 0, 32'h1004, 0, 0);
    step("pred_t",     32'h1000, 1, 32'h1000, 0, 32'h0,    1, 1, 32'h2000, 1, 1);
    step("weak_nt",    32'h1000, 1, 32'h1000, 0, 32'h0,    0, 0, 32'h1004, 2, 2);
    step("strong_nt",  32'h1000, 0, 0, 0, 0, 0,              0, 32'h1004, 3, 2);

    // Four taken updates saturate at strong-T; one not-taken still predicts taken.
    step("sat1", 32'h1000, 1, 32'h1000, 1, 32'h3000, 1, 0, 32'h1004, 3, 2);
    step("sat2", 32'h1000, 1, 32'h1000, 1, 32'h3000, 0, 0, 32'h1004, 4, 3);
    step("sat3", 32'h1000, 1, 32'h1000, 1, 32'h3000, 0, 1, 32'h3000, 5, 3);
    step("sat4", 32'h1000, 1, 32'h1000, 1, 32'h3000, 0, 1, 32'h3000, 6, 3);
    step("sat_nt", 32'h1000, 1, 32'h1000, 0, 32'h0,  0, 1, 32'h3000, 7, 3);
    step("still_t", 32'h1000, 0, 0, 0, 0, 0,             1, 32'h3000, 8, 3);

    // Frozen: update ignored.
    rdy_in = 1'b0;
    step("frozen",   32'h1000, 1, 32'h1000, 0, 32'h0, 1, 1, 32'h3000, 8, 3);
    rdy_in = 1'b1;
    step("unfrozen", 32'h1000, 0, 0, 0, 0, 0,          1, 32'h3000, 8, 3);

    // Alias on index 0 evicts 0x1000.
    step("alias_upd",  32'h1100, 1, 32'h1100, 0, 32'h0, 0, 0, 32'h1104, 8, 3);
    step("alias_old",  32'h1000, 0, 0, 0, 0, 0,          0, 32'h1004, 9, 3);
    step("alias_new",  32'h1100, 0, 0, 0, 0, 0,          0, 32'h1104, 9, 3);

    // Taken allocate on miss lands as weak-T with target.
    step("alloc_t",    32'h1104, 1, 32'h1104, 1, 32'h5000, 0, 0, 32'h1108, 9, 3);
    step("alloc_pred", 32'h1104, 0, 0, 0, 0, 0,              1, 32'h5000, 10, 3);

    // Top index and +4 wrap.
    step("wrap",       32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 32'h40, 0, 0, 32'h0,  10, 3);
    step("top_pred",   32'hFFFF_FFFC, 0, 0, 0, 0, 0,               1, 32'h40, 11, 3);

    // Preloaded saturated mispredict counter holds on a further mispredict.
    force dut.stat_mispredicts_q = 32'hFFFF_FFFF;
    #1;
    release dut.stat_mispredicts_q;
    step("mp_sat",  32'h2000, 1, 32'h2000, 0, 32'h0, 1, 0, 32'h2004, 11, 32'hFFFF_FFFF);
    step("mp_hold", 32'h2000, 0, 0, 0, 0, 0,          0, 32'h2004, 12, 32'hFFFF_FFFF);

    // Burst of updates interrupted by asynchronous reset.
    step("burst1", 32'h1000, 1, 32'h1000, 1, 32'h6000, 1, 0, 32'h1004, 12, 32'hFFFF_FFFF);
    step("burst2", 32'h1000, 1, 32'h1104, 0, 32'h0,    1, 1, 32'h6000, 13, 32'hFFFF_FFFF);
    rst_in = 1'b0;
    step("mid_rst", 32'h1000, 1, 32'h1000, 1, 32'h7000, 1, 0, 32'h1004, 0, 0);
    rst_in = 1'b1;
    step("rst_0",   32'h1000, 0, 0, 0, 0, 0, 0, 32'h1004, 0, 0);
    step("rst_1",   32'h1104, 0, 0, 0, 0, 0, 0, 32'h1108, 0, 0);
    chk_en = 1'b0;

    @(negedge clk_in);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
